snake_step_ctrl: RTL and testbench
==================================

# snake_step_ctrl

Movement scheduler for the snake game. It divides a base time tick into game steps using a 5-bit wrap-around step timer of the same form as the team's counter block. On each step it emits one-cycle, one-hot enables that drive the head X/Y position counters. It also owns the run/pause/game-over state machine and direction arbitration, including rejection of 180° reversals. It sits between the input decoder and the position counters, upstream of the collision checker.

## Interface
Parameters:
- PERIOD_W, 5, width of the step-period input and internal step timer
- SCORE_W, 8, width of the step counter output

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- tick  in  1  base time pulse, one cycle wide, arbitrary spacing
- period  in  PERIOD_W  ticks per step minus one; sampled every tick
- start  in  1  begin/restart game (level; acted on in IDLE or OVER)
- pause  in  1  level; hold game while high
- dir_in  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- dir_valid  in  1  dir_in qualifier, one-cycle request
- collision  in  1  from collision checker; ends game
- step  out  1  one-cycle pulse per game step
- x_inc, x_dec, y_inc, y_dec  out  1 each  one-hot position-counter enables, valid only with step
- dir  out  2  committed direction
- running  out  1  high in RUN
- game_over  out  1  high in OVER
- steps  out  SCORE_W  steps taken this game, saturating

## Operation
- States: IDLE (reset), RUN, PAUSE, OVER. Priority when events coincide: reset > collision > pause > start.
- IDLE: start=1 -> RUN. On entry, clear the timer and steps, and set dir and pending to 01.
- RUN: collision=1 -> OVER. Otherwise pause=1 -> PAUSE. start is ignored.
- PAUSE: collision=1 -> OVER. Otherwise pause=0 -> RUN. The timer is frozen, ticks are ignored, and direction requests are still accepted.
- OVER: start=1 -> RUN with the same clears as the IDLE entry. All enables are held low.
- Step timer (RUN only): on tick, if timer==period, the timer wraps to 0 and a step is issued. Otherwise the timer increments by 1.
- Step spacing is period+1 ticks. period=0 gives one step per tick.
- If period is lowered below the current timer value, the timer keeps counting to its 5-bit max, wraps to 0, and issues no step. The next match then issues a step.
- Direction arbitration:
  - A request is accepted when dir_valid=1, state is RUN or PAUSE, and dir_in != (dir XOR 2'b10).
  - The reversal comparison is against the committed dir, not the pending value.
  - An accepted request overwrites pending; the last accepted request before a step wins.
- At each step, dir <= pending. The enable pulsed is the one for the new direction: up -> y_dec, down -> y_inc, right -> x_inc, left -> x_dec.
- steps increments by 1 on each step and saturates at 2^SCORE_W-1.

## Timing
- Reset values:
  - state IDLE, timer 0, dir 01, pending 01, steps 0.
  - step, x_inc, x_dec, y_inc, y_dec, running and game_over all 0.
  - Reset asserted mid-game returns to IDLE immediately, even during a step pulse.
- The step and enable outputs are registered. They assert in the cycle after the clock edge that samples the matching tick, and last exactly one cycle.
- dir updates on the same edge that raises step. dir and the enable are consistent in that cycle.
- A dir request accepted on the edge that issues a step is not used for that step; it takes effect at the next step.
- Collision in the same cycle as a matching tick: the transition to OVER wins and no step is issued.
- running and game_over are registered from state, so they lag state transitions by zero cycles (they are decoded state flops).
- Latency from start to the first step is (period+1) ticks plus 1 cycle.

## Test plan
- Reset then start, with period=3 and ticks every 2 cycles -> first step after the 4th tick. x_inc pulses each step, dir=01, and steps=1,2,3 at each step.
- With dir=01 (right), request dir_in=11 (left) -> rejected, and the next step still pulses x_inc. Then request 00 followed by 10 before the step -> the last request wins, so dir=10 and y_inc pulses.
- pause=1 for 10 ticks in RUN -> no steps and the timer holds. Release pause -> the next step occurs after the remaining ticks only.
- Collision coincident with a matching tick -> no step, game_over=1 and running=0. Then start -> steps=0, dir=01, back in RUN.
- Lower period from 20 to 2 while the timer is at 10 -> the timer wraps at 31 with no step, then steps every 3 ticks.
- Force 300 steps with period=0 -> steps saturates at 255. Asserting reset mid-step pulse clears all outputs asynchronously.

Source files
------------

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: movement scheduler for the snake game.
//
// Divides the base tick into game steps with a wrap-around step timer. It issues one-cycle,
// one-hot enables for the head position counters, runs the IDLE/RUN/PAUSE/OVER game state
// machine and arbitrates direction requests, rejecting 180-degree reversals.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   tick       base time pulse
//   period     ticks per step minus one
//   start      begin/restart game (acted on in IDLE or OVER)
//   pause      hold game while high
//   dir_in     requested direction: 00 up, 01 right, 10 down, 11 left
//   dir_valid  dir_in qualifier
//   collision  ends the game
//   step       one-cycle pulse per game step
//   x_inc, x_dec, y_inc, y_dec  one-hot position enables, only with step
//   dir        committed direction
//   running    high in RUN
//   game_over  high in OVER
//   steps      steps taken this game, saturating
module snake_step_ctrl #(
    parameter int unsigned PERIOD_W = 5,
    parameter int unsigned SCORE_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic [PERIOD_W-1:0] period,
    input  logic                start,
    input  logic                pause,
    input  logic [1:0]          dir_in,
    input  logic                dir_valid,
    input  logic                collision,
    output logic                step,
    output logic                x_inc,
    output logic                x_dec,
    output logic                y_inc,
    output logic                y_dec,
    output logic [1:0]          dir,
    output logic                running,
    output logic                game_over,
    output logic [SCORE_W-1:0]  steps
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StOver} state_e;

    localparam logic [1:0] DirUp    = 2'b00;
    localparam logic [1:0] DirRight = 2'b01;
    localparam logic [1:0] DirDown  = 2'b10;
    localparam logic [1:0] DirLeft  = 2'b11;

    localparam logic [SCORE_W-1:0] StepsMax = '1;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] timer_q, timer_d;
    logic [1:0]          pending_q, pending_d;
    logic [1:0]          dir_d;
    logic [SCORE_W-1:0]  steps_d;
    logic                accept;
    logic                fire;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q;
        dir_d     = dir;
        steps_d   = steps;
        fire      = 1'b0;

        // Reversal is judged against the committed direction, not the pending one.
        accept = dir_valid && ((state_q == StRun) || (state_q == StPause)) &&
                 (dir_in != (dir ^ 2'b10));

        case (state_q)
            StIdle, StOver: begin
                if (start) begin
                    state_d   = StRun;
                    timer_d   = '0;
                    steps_d   = '0;
                    dir_d     = DirRight;
                    pending_d = DirRight;
                end
            end
            StRun: begin
                if (collision) begin
                    state_d = StOver;
                end else if (pause) begin
                    state_d = StPause;
                end else if (tick) begin
                    // A lowered period below the timer lets it run to all-ones and wrap
                    // without a step; only an exact match fires.
                    if (timer_q == period) begin
                        timer_d = '0;
                        fire    = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            StPause: begin
                if (collision) begin
                    state_d = StOver;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fire) begin
            dir_d = pending_q;
            if (steps != StepsMax) begin
                steps_d = steps + 1'b1;
            end
        end

        // Applied after the step commit so a request on the step edge waits for the next step.
        if (accept) begin
            pending_d = dir_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            pending_q <= DirRight;
            dir       <= DirRight;
            steps     <= '0;
            step      <= 1'b0;
            x_inc     <= 1'b0;
            x_dec     <= 1'b0;
            y_inc     <= 1'b0;
            y_dec     <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            dir       <= dir_d;
            steps     <= steps_d;
            step      <= fire;
            x_inc     <= fire && (pending_q == DirRight);
            x_dec     <= fire && (pending_q == DirLeft);
            y_inc     <= fire && (pending_q == DirDown);
            y_dec     <= fire && (pending_q == DirUp);
            running   <= (state_d == StRun);
            game_over <= (state_d == StOver);
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
module tb_snake_step_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [4:0] period = 5'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic       dir_valid = 1'b0;
    logic       collision = 1'b0;
    logic       step, x_inc, x_dec, y_inc, y_dec, running, game_over;
    logic [1:0] dir;
    logic [7:0] steps;

    int tests_run = 0;
    int tests_failed = 0;

    snake_step_ctrl #(
        .PERIOD_W(5),
        .SCORE_W (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .period   (period),
        .start    (start),
        .pause    (pause),
        .dir_in   (dir_in),
        .dir_valid(dir_valid),
        .collision(collision),
        .step     (step),
        .x_inc    (x_inc),
        .x_dec    (x_dec),
        .y_inc    (y_inc),
        .y_dec    (y_dec),
        .dir      (dir),
        .running  (running),
        .game_over(game_over),
        .steps    (steps)
    );

    always #5 clock = ~clock;

    // Reference model: game mode, tick count within the step, directions, score.
    localparam int MIdle = 0, MRun = 1, MPause = 2, MOver = 3;
    int       m_mode, m_timer, m_dir, m_pend, m_steps;
    bit       e_step;
    bit [3:0] e_en;  // {x_inc, x_dec, y_inc, y_dec}
    bit [3:0] en_of_dir [4];

    function automatic bit [3:0] en_vec();
        return {x_inc, x_dec, y_inc, y_dec};
    endfunction

    task automatic model_reset();
        m_mode = MIdle; m_timer = 0; m_dir = 1; m_pend = 1; m_steps = 0;
        e_step = 0; e_en = 4'b0000;
    endtask

    task automatic model_clk();
        bit take;
        take = dir_valid && (m_mode == MRun || m_mode == MPause) &&
               (int'(dir_in) != ((m_dir + 2) % 4));
        e_step = 0;
        if (m_mode == MIdle || m_mode == MOver) begin
            if (start) begin
                m_mode = MRun; m_timer = 0; m_steps = 0; m_dir = 1; m_pend = 1;
            end
        end else if (collision) begin
            m_mode = MOver;
        end else if (m_mode == MPause) begin
            if (!pause) m_mode = MRun;
        end else if (pause) begin
            m_mode = MPause;
        end else if (tick) begin
            if (m_timer == int'(period)) begin
                m_timer = 0;
                e_step = 1;
            end else begin
                m_timer = (m_timer + 1) % 32;
            end
        end
        if (e_step) begin
            m_dir = m_pend;
            if (m_steps < 255) m_steps = m_steps + 1;
        end
        if (take) m_pend = dir_in;
        e_en = e_step ? en_of_dir[m_dir] : 4'b0000;
    endtask

    task automatic cyc(input bit t, input bit dv, input logic [1:0] di, input bit c);
        @(negedge clock);
        tick = t; dir_valid = dv; dir_in = di; collision = c;
        model_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        model_reset();
        tests_run++;
        if ({step, en_vec(), running, game_over} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b want 0", {step, en_vec(), running, game_over});
        end
        tests_run++;
        if (dir !== 2'b01 || steps !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_dir_steps got dir=%b steps=%0d want dir=01 steps=0", dir, steps);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_steps();
        int nt = 0, ns = 0;
        period = 5'd3;
        start = 1'b1;
        cyc(0, 0, 2'b00, 0);
        start = 1'b0;
        tests_run++;
        if (running !== 1'b1 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_run got running=%b over=%b want 1 0", running, game_over);
        end
        for (int i = 0; i < 24; i++) begin
            cyc(i[0], 0, 2'b00, 0);
            nt += int'(i[0]);
            tests_run++;
            if (step !== e_step) begin
                tests_failed++;
                $display("FAIL basic_step cyc %0d got %b want %b", i, step, e_step);
            end
            if (step === 1'b1) begin
                ns++;
                tests_run++;
                if (nt != 4 * ns || en_vec() !== 4'b1000 || dir !== 2'b01 || steps !== 8'(ns)) begin
                    tests_failed++;
                    $display("FAIL basic_pulse got ticks=%0d en=%b dir=%b steps=%0d want %0d 1000 01 %0d",
                             nt, en_vec(), dir, steps, 4 * ns, ns);
                end
            end
        end
        tests_run++;
        if (ns != 3) begin
            tests_failed++;
            $display("FAIL basic_count got %0d want 3", ns);
        end
    endtask

    task automatic test_reversal();
        bit found;
        cyc(0, 1, 2'b11, 0);  // left while moving right: reversal
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1, 0, 2'b00, 0);
            if (step === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || en_vec() !== 4'b1000 || dir !== 2'b01) begin
            tests_failed++;
            $display("FAIL reversal_reject got found=%b en=%b dir=%b want 1 1000 01", found, en_vec(), dir);
        end
        cyc(0, 1, 2'b00, 0);
        cyc(0, 1, 2'b10, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1, 0, 2'b00, 0);
            if (step === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || en_vec() !== 4'b0010 || dir !== 2'b10) begin
            tests_failed++;
            $display("FAIL last_request_wins got found=%b en=%b dir=%b want 1 0010 10", found, en_vec(), dir);
        end
    endtask

    task automatic test_pause();
        int remain, nt;
        bit found, stray;
        cyc(1, 0, 2'b00, 0);
        cyc(1, 0, 2'b00, 0);
        remain = int'(period) - m_timer + 1;
        pause = 1'b1;
        cyc(0, 0, 2'b00, 0);
        tests_run++;
        if (running !== 1'b0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_state got running=%b over=%b want 0 0", running, game_over);
        end
        cyc(0, 1, 2'b11, 0);  // left while moving down: accepted in PAUSE
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 2'b00, 0);
            if (step !== 1'b0) stray = 1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL pause_hold got step during pause want none");
        end
        pause = 1'b0;
        cyc(0, 0, 2'b00, 0);
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL pause_release got running=%b want 1", running);
        end
        nt = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1, 0, 2'b00, 0);
            nt++;
            if (step === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || nt != remain || en_vec() !== 4'b0100 || dir !== 2'b11) begin
            tests_failed++;
            $display("FAIL pause_resume got ticks=%0d en=%b dir=%b want %0d 0100 11",
                     nt, en_vec(), dir, remain);
        end
    endtask

    task automatic test_collision();
        bit stray;
        for (int i = 0; i < 40 && m_timer != int'(period); i++) cyc(1, 0, 2'b00, 0);
        cyc(1, 0, 2'b00, 1);
        tests_run++;
        if (step !== 1'b0 || game_over !== 1'b1 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL collision_tick got step=%b over=%b running=%b want 0 1 0",
                     step, game_over, running);
        end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 2'b00, 0);
            if (en_vec() !== 4'b0 || step !== 1'b0) stray = 1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL over_quiet got enables in OVER want none");
        end
        start = 1'b1;
        cyc(0, 0, 2'b00, 0);
        start = 1'b0;
        tests_run++;
        if (steps !== 8'd0 || dir !== 2'b01 || running !== 1'b1 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart got steps=%0d dir=%b running=%b over=%b want 0 01 1 0",
                     steps, dir, running, game_over);
        end
    endtask

    task automatic test_period_lower();
        int nt;
        bit found;
        period = 5'd20;
        for (int i = 0; i < 10; i++) cyc(1, 0, 2'b00, 0);
        period = 5'd2;
        nt = 0; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1, 0, 2'b00, 0);
            nt++;
            if (step === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || nt != 25) begin
            tests_failed++;
            $display("FAIL period_lower_wrap got ticks=%0d found=%b want 25", nt, found);
        end
        nt = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1, 0, 2'b00, 0);
            nt++;
            if (step === 1'b1) found = 1;
        end
        tests_run++;
        if (!found || nt != 3) begin
            tests_failed++;
            $display("FAIL period_lower_next got ticks=%0d want 3", nt);
        end
    endtask

    task automatic test_saturation();
        period = 5'd0;
        for (int i = 0; i < 300; i++) begin
            cyc(1, 0, 2'b00, 0);
            tests_run++;
            if (step !== e_step || steps !== 8'(m_steps)) begin
                tests_failed++;
                $display("FAIL sat_track cyc %0d got step=%b steps=%0d want %b %0d",
                         i, step, steps, e_step, m_steps);
            end
        end
        tests_run++;
        if (steps !== 8'd255 || step !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_value got steps=%0d step=%b want 255 1", steps, step);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if ({step, en_vec(), running, game_over} !== 7'b0 || steps !== 8'd0 || dir !== 2'b01) begin
            tests_failed++;
            $display("FAIL async_reset got flags=%b steps=%0d dir=%b want 0 0 01",
                     {step, en_vec(), running, game_over}, steps, dir);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        bit [14:0] got, want;
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 4) pause = ~pause;
            if ($urandom_range(0, 99) < 5) period = 5'($urandom_range(0, 6));
            cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
                2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 2));
            got  = {step, en_vec(), dir, running, game_over, steps};
            want = {e_step, e_en, 2'(m_dir), m_mode == MRun, m_mode == MOver, 8'(m_steps)};
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random cyc %0d got %b want %b", i, got, want);
            end
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        en_of_dir[0] = 4'b0001;  // up    -> y_dec
        en_of_dir[1] = 4'b1000;  // right -> x_inc
        en_of_dir[2] = 4'b0010;  // down  -> y_inc
        en_of_dir[3] = 4'b0100;  // left  -> x_dec
        model_reset();
        test_reset();
        test_basic_steps();
        test_reversal();
        test_pause();
        test_collision();
        test_period_lower();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
